shift_reg_univ: RTL and testbench

Parametrised universal register, the generalised successor to the team's 4-bit universal register. It adds configurable width, four shift modes (logical, serial-fill, rotate, arithmetic), a multi-cycle shift-by-N engine with a busy/done handshake, and a carry/shift-out flag. It sits in the datapath wherever a loadable, count-capable shifting register is needed, and is driven by the control FSM.

---
 rtl/shift_reg_univ.sv | 213 +++++++++++++++++++++
 tb/tb_shift_reg_univ.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// shift_reg_univ -- parametrised universal register.
//
// Loadable, countable shifting register driven by the control FSM.
// Single-step commands (cl > ld > inc > dec > sr > sl > start) execute in
// IDLE. `start` runs a multi-cycle shift of `amt` positions (clamped to
// WIDTH) with a busy/done handshake. `cout` holds the carry/borrow of the
// last inc/dec, or the last bit shifted out.
//
// Optional build macro:
//   SHIFT_REG_UNIV_SAT_EN  inc/dec saturate instead of wrapping
//                          (cout=1 on a clamped operation, else 0).
//
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   cl, ld, in     sync clear, parallel load of `in`
//   inc, dec       increment / decrement by 1
//   sr, sl         single-step shift right / left per `mode`
//   ir, il         serial fill bits for mode 01 (ir at MSB, il at LSB)
//   mode           00 logical, 01 serial-fill, 10 rotate, 11 arithmetic
//   start,dir,amt  multi-cycle shift request (dir: 0 right, 1 left)
//   out, cout      register contents, carry/shift-out flag
//   busy, done     multi-cycle shift in progress / one-cycle completion pulse
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             sl,
  input  logic             ir,
  input  logic             il,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW-1:0]    amt_c;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;

  // Returns {shifted-out bit, shifted value}.
  function automatic logic [WIDTH:0] shift_one(
    input logic [WIDTH-1:0] v,
    input logic             left,
    input logic [1:0]       m,
    input logic             s_ir,
    input logic             s_il
  );
    logic fill;
    fill = 1'b0;
    if (left) begin
      case (m)
        2'b01:   fill = s_il;
        2'b10:   fill = v[WIDTH-1];
        default: fill = 1'b0;
      endcase
      return {v[WIDTH-1], v[WIDTH-2:0], fill};
    end else begin
      case (m)
        2'b01:   fill = s_ir;
        2'b10:   fill = v[0];
        2'b11:   fill = v[WIDTH-1];
        default: fill = 1'b0;
      endcase
      return {v[0], fill, v[WIDTH-1:1]};
    end
  endfunction

  assign amt_c    = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;
  assign inc_sum  = {1'b0, out_q} + (WIDTH+1)'(1);
  assign dec_diff = {1'b0, out_q} - (WIDTH+1)'(1);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cout_d  = cout_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (cl) begin
          out_d  = '0;
          cout_d = 1'b0;
        end else if (ld) begin
          out_d  = in;
          cout_d = 1'b0;
        end else if (inc) begin
`ifdef SHIFT_REG_UNIV_SAT_EN
          if (&out_q) begin
            cout_d = 1'b1;
          end else begin
            out_d  = inc_sum[WIDTH-1:0];
            cout_d = 1'b0;
          end
`else
          {cout_d, out_d} = inc_sum;
`endif
        end else if (dec) begin
`ifdef SHIFT_REG_UNIV_SAT_EN
          if (out_q == '0) begin
            cout_d = 1'b1;
          end else begin
            out_d  = dec_diff[WIDTH-1:0];
            cout_d = 1'b0;
          end
`else
          {cout_d, out_d} = dec_diff;
`endif
        end else if (sr) begin
          {cout_d, out_d} = shift_one(out_q, 1'b0, mode, ir, il);
        end else if (sl) begin
          {cout_d, out_d} = shift_one(out_q, 1'b1, mode, ir, il);
        end else if (start && !done_q) begin
          // done_q still high means the previous operation's pulse is on
          // the output; a new start waits until it has cleared.
          dir_d  = dir;
          mode_d = mode;
          if (amt_c == '0) begin
            state_d = S_DONE;
          end else begin
            {cout_d, out_d} = shift_one(out_q, dir, mode, ir, il);
            rem_d   = amt_c - AW'(1);
            state_d = (amt_c == AW'(1)) ? S_DONE : S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (cl) begin
          out_d   = '0;
          cout_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          {cout_d, out_d} = shift_one(out_q, dir_q, mode_q, ir, il);
          rem_d = rem_q - AW'(1);
          if (rem_q == AW'(1)) state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (cl) begin
          out_d  = '0;
          cout_d = 1'b0;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Flags lag the state by one edge, so busy covers the cycles after the
    // second..last shift edge and done follows the DONE state; an abort
    // with cl suppresses both.
    busy_d = (state_q == S_SHIFT) && !cl;
    done_d = (state_q == S_DONE) && !cl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      cout_q  <= 1'b0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int AW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cl = 0, ld = 0, inc = 0, dec = 0, sr = 0, sl = 0;
  logic             ir = 0, il = 0, start = 0, dir = 0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] in = '0;
  logic [AW-1:0]    amt = '0;
  logic [WIDTH-1:0] out;
  logic             cout, busy, done;

  int checks = 0;
  int errors = 0;

  shift_reg_univ #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in), .inc(inc),
    .dec(dec), .sr(sr), .sl(sl), .ir(ir), .il(il), .mode(mode),
    .start(start), .dir(dir), .amt(amt), .out(out), .cout(cout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    ld = 1; in = v; tick(); ld = 0;
  endtask

  // Samples busy/done for cycles first_cyc..12 after E0 (cycle k follows
  // edge E0+k-1); bounded, so it cannot hang.
  task automatic measure(input int first_cyc, output int busy_cnt,
                         output int first_busy, output int done_cnt,
                         output int done_at);
    busy_cnt = 0; first_busy = 0; done_cnt = 0; done_at = 0;
    for (int c = first_cyc; c <= 12; c++) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = c;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", out); end
    checks++; if ({cout, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {cout, busy, done}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    load(8'h59);
    inc = 1; tick(); inc = 0;
    checks++; if (out !== 8'h5A) begin errors++; $display("FAIL mid_inc got %h exp 5a", out); end
    start = 1; amt = 4'd5; dir = 0; mode = 2'b10; tick(); start = 0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({out, cout, busy, done} !== 11'h000) begin errors++; $display("FAIL async_reset got %h/%b%b%b exp 00/000", out, cout, busy, done); end
    #2 rst_n = 1'b1;
    tick();
    load(8'h33);
    cl = 1; ld = 1; inc = 1; in = 8'hAB; tick(); cl = 0; ld = 0; inc = 0;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL cl_priority got %h exp 00", out); end
  endtask

  task automatic test_incdec();
    logic [WIDTH-1:0] e_out;
    logic             e_c;
    load(8'hFF);
    inc = 1; tick(); inc = 0;
`ifdef SHIFT_REG_UNIV_SAT_EN
    e_out = 8'hFF; e_c = 1'b1;
`else
    e_out = 8'h00; e_c = 1'b1;
`endif
    checks++; if ({out, cout} !== {e_out, e_c}) begin errors++; $display("FAIL inc_top got %h/%b exp %h/%b", out, cout, e_out, e_c); end
    load(8'h00);
    dec = 1; tick(); dec = 0;
`ifdef SHIFT_REG_UNIV_SAT_EN
    e_out = 8'h00; e_c = 1'b1;
`else
    e_out = 8'hFF; e_c = 1'b1;
`endif
    checks++; if ({out, cout} !== {e_out, e_c}) begin errors++; $display("FAIL dec_zero got %h/%b exp %h/%b", out, cout, e_out, e_c); end
    load(8'h7F);
    inc = 1; tick(); inc = 0;
    checks++; if ({out, cout} !== {8'h80, 1'b0}) begin errors++; $display("FAIL inc_mid got %h/%b exp 80/0", out, cout); end
    dec = 1; tick(); dec = 0;
    checks++; if ({out, cout} !== {8'h7F, 1'b0}) begin errors++; $display("FAIL dec_mid got %h/%b exp 7f/0", out, cout); end
    load(8'h10);
    inc = 1; dec = 1; tick(); inc = 0; dec = 0;
    checks++; if (out !== 8'h11) begin errors++; $display("FAIL inc_over_dec got %h exp 11", out); end
  endtask

  task automatic test_single_shift();
    logic [WIDTH-1:0] exp_sr [4];
    logic [WIDTH-1:0] exp_sl [4];
    exp_sr = '{8'h40, 8'hC0, 8'hC0, 8'hC0};
    exp_sl = '{8'h02, 8'h03, 8'h03, 8'h02};
    ir = 1; il = 1;
    for (int m = 0; m < 4; m++) begin
      load(8'h81);
      mode = 2'(m); sr = 1; tick(); sr = 0;
      checks++; if ({out, cout} !== {exp_sr[m], 1'b1}) begin errors++; $display("FAIL sr_mode%0d got %h/%b exp %h/1", m, out, cout, exp_sr[m]); end
      load(8'h81);
      sl = 1; tick(); sl = 0;
      checks++; if ({out, cout} !== {exp_sl[m], 1'b1}) begin errors++; $display("FAIL sl_mode%0d got %h/%b exp %h/1", m, out, cout, exp_sl[m]); end
    end
    ir = 0; il = 0;
    load(8'h01);
    mode = 2'b11; sr = 1; tick(); sr = 0;
    checks++; if ({out, cout} !== {8'h00, 1'b1}) begin errors++; $display("FAIL sr_arith_lsb got %h/%b exp 00/1", out, cout); end
    load(8'h80);
    mode = 2'b00; sr = 1; sl = 1; tick(); sr = 0; sl = 0;
    checks++; if ({out, cout} !== {8'h40, 1'b0}) begin errors++; $display("FAIL sr_over_sl got %h/%b exp 40/0", out, cout); end
  endtask

  task automatic test_multi_rotate();
    int bc, fb, dc, da;
    load(8'h96);
    start = 1; amt = 4'd3; dir = 0; mode = 2'b10; tick();
    start = 0; dir = 1; mode = 2'b00;
    measure(1, bc, fb, dc, da);
    checks++; if (bc !== 2 || fb !== 2) begin errors++; $display("FAIL rot_busy got cnt %0d first %0d exp cnt 2 first 2", bc, fb); end
    checks++; if (dc !== 1 || da !== 4) begin errors++; $display("FAIL rot_done got cnt %0d at %0d exp cnt 1 at 4", dc, da); end
    checks++; if ({out, cout} !== {8'hD2, 1'b1}) begin errors++; $display("FAIL rot_result got %h/%b exp d2/1", out, cout); end
  endtask

  task automatic test_multi_clamp();
    int bc, fb, dc, da;
    load(8'hFF);
    start = 1; amt = 4'd12; dir = 1; mode = 2'b00; tick(); start = 0;
    measure(1, bc, fb, dc, da);
    checks++; if (bc !== 7 || fb !== 2) begin errors++; $display("FAIL clamp_busy got cnt %0d first %0d exp cnt 7 first 2", bc, fb); end
    checks++; if (dc !== 1 || da !== 9) begin errors++; $display("FAIL clamp_done got cnt %0d at %0d exp cnt 1 at 9", dc, da); end
    checks++; if ({out, cout} !== {8'h00, 1'b1}) begin errors++; $display("FAIL clamp_result got %h/%b exp 00/1", out, cout); end
  endtask

  task automatic test_multi_zero();
    int bc, fb, dc, da;
    load(8'h3C);
    start = 1; amt = 4'd0; dir = 0; mode = 2'b00; tick(); start = 0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_cyc1 got %b exp 00", {busy, done}); end
    inc = 1; tick(); inc = 0;
    measure(2, bc, fb, dc, da);
    checks++; if (bc !== 0 || dc !== 1 || da !== 2) begin errors++; $display("FAIL zero_flags got busy %0d done %0d at %0d exp 0 1 at 2", bc, dc, da); end
    checks++; if ({out, cout} !== {8'h3C, 1'b0}) begin errors++; $display("FAIL zero_result got %h/%b exp 3c/0", out, cout); end
  endtask

  task automatic test_abort();
    int bc, fb, dc, da;
    load(8'h0F);
    start = 1; amt = 4'd5; dir = 0; mode = 2'b00; tick(); start = 0;
    tick();
    checks++; if ({busy, out} !== {1'b1, 8'h03}) begin errors++; $display("FAIL abort_busy1 got %b/%h exp 1/03", busy, out); end
    inc = 1; tick(); inc = 0;
    checks++; if ({busy, out} !== {1'b1, 8'h01}) begin errors++; $display("FAIL inc_ignored got %b/%h exp 1/01", busy, out); end
    cl = 1; tick(); cl = 0;
    checks++; if ({out, cout} !== {8'h00, 1'b0}) begin errors++; $display("FAIL abort_clear got %h/%b exp 00/0", out, cout); end
    measure(4, bc, fb, dc, da);
    checks++; if (bc !== 0 || dc !== 0) begin errors++; $display("FAIL abort_flags got busy %0d done %0d exp 0 0", bc, dc); end
    inc = 1; tick(); inc = 0;
    checks++; if (out !== 8'h01) begin errors++; $display("FAIL abort_idle got %h exp 01", out); end
  endtask

  initial begin
    #12;
    test_reset();
    test_reset_mid();
    test_incdec();
    test_single_shift();
    test_multi_rotate();
    test_multi_clamp();
    test_multi_zero();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
